uart_reg_loader: RTL and testbench

Serial-to-register-file loader for the lab board: receives 8N1 UART bytes on `UART_RXD`, assembles them into 5-byte write packets and drives the RegisterFile write port (`wa3`/`wd3`/`we3`). This lets a host PC load register contents at run time instead of entering them by hand on `SW`. It sits between the board `UART_RXD` pin and the RegisterFile write port. `rx_byte` and `pkt_count` feed the LCD/HEX displays for debug.

---
 rtl/uart_reg_loader.sv | 218 +++++++++++++++++++++
 tb/tb_uart_reg_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_loader.sv
// UART 8N1 byte receiver feeding a 5-byte packet assembler that drives a
// register-file write port (wa3/wd3/we3), with byte/packet debug outputs.
module uart_reg_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [2:0]  wa3,
  output logic [31:0] wd3,
  output logic        we3,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [7:0]  pkt_count,
  output logic [2:0]  rx_state_dbg,
  output logic [2:0]  asm_state_dbg
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    ASM_CMD = 3'd0,
    ASM_D0  = 3'd1,
    ASM_D1  = 3'd2,
    ASM_D2  = 3'd3,
    ASM_D3  = 3'd4
  } asm_state_t;

  // Two-flop synchronizer; both stages reset to the idle-high line level.
  logic rxd_meta_q, rxd_s_q;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;

  asm_state_t       asm_q, asm_d;
  logic [2:0]       addr_q, addr_d;
  logic [23:0]      shadow_q, shadow_d;
  logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [2:0]       wa3_q, wa3_d;
  logic [31:0]      wd3_q, wd3_d;
  logic             we3_q, we3_d;
  logic [7:0]       pkt_count_q, pkt_count_d;

  always_comb begin
    rx_state_d  = rx_state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxd_s_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d  = '0;
          rx_state_d = rxd_s_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BIT_M1) begin
          clk_cnt_d = '0;
          if (rxd_s_q) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxd_s_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // The timeout measures line-idle time between bytes of a packet: it only
  // advances while the receiver sits in IDLE, so a byte in flight never expires.
  always_comb begin
    asm_d       = asm_q;
    addr_d      = addr_q;
    shadow_d    = shadow_q;
    idle_cnt_d  = idle_cnt_q;
    wa3_d       = wa3_q;
    wd3_d       = wd3_q;
    we3_d       = 1'b0;
    pkt_count_d = pkt_count_q;
    case (asm_q)
      ASM_CMD: begin
        idle_cnt_d = '0;
        if (rx_valid_q && rx_byte_q[7:3] == 5'b10100) begin
          addr_d = rx_byte_q[2:0];
          asm_d  = ASM_D0;
        end
      end
      ASM_D0, ASM_D1, ASM_D2, ASM_D3: begin
        if (rx_valid_q) begin
          idle_cnt_d = '0;
          case (asm_q)
            ASM_D0: begin shadow_d[7:0]   = rx_byte_q; asm_d = ASM_D1; end
            ASM_D1: begin shadow_d[15:8]  = rx_byte_q; asm_d = ASM_D2; end
            ASM_D2: begin shadow_d[23:16] = rx_byte_q; asm_d = ASM_D3; end
            default: begin
              wd3_d       = {rx_byte_q, shadow_q};
              wa3_d       = addr_q;
              we3_d       = 1'b1;
              pkt_count_d = pkt_count_q + 1'b1;
              asm_d       = ASM_CMD;
            end
          endcase
        end else if (frame_err_q) begin
          asm_d = ASM_CMD;
        end else if (rx_state_q == RX_IDLE) begin
          if (idle_cnt_q == TO_M1) begin
            asm_d = ASM_CMD;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: asm_d = ASM_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      rx_state_q  <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      asm_q       <= ASM_CMD;
      addr_q      <= '0;
      shadow_q    <= '0;
      idle_cnt_q  <= '0;
      wa3_q       <= '0;
      wd3_q       <= '0;
      we3_q       <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      rxd_meta_q  <= rxd;
      rxd_s_q     <= rxd_meta_q;
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      asm_q       <= asm_d;
      addr_q      <= addr_d;
      shadow_q    <= shadow_d;
      idle_cnt_q  <= idle_cnt_d;
      wa3_q       <= wa3_d;
      wd3_q       <= wd3_d;
      we3_q       <= we3_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign wa3           = wa3_q;
  assign wd3           = wd3_q;
  assign we3           = we3_q;
  assign rx_byte       = rx_byte_q;
  assign rx_valid      = rx_valid_q;
  assign frame_err     = frame_err_q;
  assign pkt_count     = pkt_count_q;
  assign rx_state_dbg  = rx_state_q;
  assign asm_state_dbg = asm_q;

endmodule

// File: tb/tb_uart_reg_loader.sv
// Directed bench for uart_reg_loader: serial driver tasks push expected bytes,
// frame errors and register writes; a negedge monitor pops and compares them.
module tb_uart_reg_loader;

  localparam int CPB = 16;
  localparam int TOB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [2:0]  wa3;
  logic [31:0] wd3;
  logic        we3;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_err;
  logic [7:0]  pkt_count;
  logic [2:0]  rx_state_dbg;
  logic [2:0]  asm_state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_byte_q[$];
  logic [7:0]  exp_fe_q[$];
  logic [42:0] exp_we_q[$];  // {pkt_count, wa3, wd3}
  logic [7:0]  exp_pkt = 8'd0;

  uart_reg_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .wa3(wa3), .wd3(wd3), .we3(we3),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
    .pkt_count(pkt_count),
    .rx_state_dbg(rx_state_dbg), .asm_state_dbg(asm_state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame; a good frame also pushes its byte on the scoreboard.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) exp_byte_q.push_back(b);
    else exp_fe_q.push_back(dut.rx_byte);
    @(negedge clk);
    rxd = 1'b0;
    idle_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle_cycles(CPB);
    end
    rxd = stop_ok;
    idle_cycles(CPB);
    rxd = 1'b1;
    if (!stop_ok) idle_cycles(CPB);
  endtask

  task automatic expect_write(input logic [2:0] a, input logic [31:0] d);
    exp_pkt = exp_pkt + 8'd1;
    exp_we_q.push_back({exp_pkt, a, d});
  endtask

  task automatic send_packet(input logic [7:0] cmd, input logic [31:0] d);
    send_byte(cmd, 1'b1);
    send_byte(d[7:0], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[23:16], 1'b1);
    send_byte(d[31:24], 1'b1);
  endtask

  // Monitor: every strobe pops one expectation of its kind.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid || frame_err || we3)
        check("strobe_exclusive", 64'(rx_valid) + 64'(frame_err) + 64'(we3), 64'd1);
      if (rx_valid) begin
        if (exp_byte_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_valid_unexpected: got byte %0h expected none", rx_byte);
        end else begin
          check("rx_byte", rx_byte, exp_byte_q.pop_front());
        end
      end
      if (frame_err) begin
        if (exp_fe_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_err_unexpected: got pulse expected none");
        end else begin
          check("rx_byte_hold_on_ferr", rx_byte, exp_fe_q.pop_front());
        end
      end
      if (we3) begin
        if (exp_we_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL we3_unexpected: got wa3=%0h wd3=%0h expected none", wa3, wd3);
        end else begin
          check("write_pkt_wa_wd", {pkt_count, wa3, wd3}, exp_we_q.pop_front());
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_wa3"}, wa3, 0);
    check({tag, "_wd3"}, wd3, 0);
    check({tag, "_we3"}, we3, 0);
    check({tag, "_rx_byte"}, rx_byte, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_pkt_count"}, pkt_count, 0);
  endtask

  initial begin
    idle_cycles(4);
    check_all_zero("reset");
    rst = 1'b0;
    idle_cycles(10);

    // Single byte
    send_byte(8'h55, 1'b1);
    idle_cycles(4);
    check("single_pkt_count", pkt_count, 8'd0);

    // Full packet, back-to-back
    expect_write(3'd3, 32'h12345678);
    send_packet(8'hA3, 32'h12345678);
    idle_cycles(4);
    check("full_pkt_count", pkt_count, 8'd1);

    // Bad command is dropped
    send_byte(8'h13, 1'b1);
    expect_write(3'd1, 32'hDEADBEEF);
    send_packet(8'hA1, 32'hDEADBEEF);
    idle_cycles(4);
    check("badcmd_pkt_count", pkt_count, 8'd2);

    // Framing error aborts the partial packet
    send_byte(8'hA2, 1'b1);
    send_byte(8'h11, 1'b0);
    expect_write(3'd2, 32'h11223344);
    send_packet(8'hA2, 32'h11223344);
    idle_cycles(4);
    check("ferr_pkt_count", pkt_count, 8'd3);
    check("hold_wa3", wa3, 3'd2);
    check("hold_wd3", wd3, 32'h11223344);

    // Glitch, then timeout
    rxd = 1'b0;
    idle_cycles(4);
    rxd = 1'b1;
    idle_cycles(3 * CPB);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    idle_cycles(5 * CPB);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    idle_cycles(4);
    check("timeout_pkt_count", pkt_count, 8'd3);
    check("timeout_hold_wd3", wd3, 32'h11223344);

    // Reset mid-packet
    send_byte(8'hA6, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");
    exp_pkt = 8'd0;
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    idle_cycles(8 * CPB);
    check("midrst_pkt_count", pkt_count, 8'd0);
    check("midrst_wd3", wd3, 32'd0);

    check("leftover_bytes", exp_byte_q.size(), 0);
    check("leftover_ferr", exp_fe_q.size(), 0);
    check("leftover_writes", exp_we_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
